// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioner.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPWait   = 2'd1,
    StPressed = 2'd2,
    StRWait   = 2'd3
  } btn_state_e;

  // Bits needed to hold 0..n inclusive; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, press/release pulses and hold flag.
module button_conditioner_ch
  import button_conditioner_pkg::*;
#(
  parameter bit          INV_BTN         = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned HOLD_CYCLES     = 27000000
) (
  input  logic clk,
  input  logic rst_i,
  input  logic btn_raw_i,
  output logic btn_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int unsigned CntW  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HcntW = cnt_width(HOLD_CYCLES);
  localparam bit          HoldEn = (HOLD_CYCLES > 0);

  localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HcntW-1:0] HcntMax  = HcntW'(HOLD_CYCLES);
  localparam logic [HcntW-1:0] HcntHold = HcntW'(HOLD_CYCLES - 1);

  logic sync1_q, sync2_q;

  btn_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HcntW-1:0] hcnt_q, hcnt_d;
  logic             btn_q, btn_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             hold_q, hold_d;

  // Synchroniser resets to the logical released level regardless of pad polarity.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i ^ INV_BTN;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    btn_d   = btn_q;
    hold_d  = hold_q;
    press_d = 1'b0;
    rel_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sync2_q) begin
          state_d = StPWait;
          cnt_d   = CntW'(1);
        end
      end
      StPWait: begin
        if (!sync2_q) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StPressed;
          btn_d   = 1'b1;
          press_d = 1'b1;
          hcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (!sync2_q) begin
          state_d = StRWait;
          cnt_d   = CntW'(1);
        end else if (HoldEn) begin
          // Saturate so the hold flag can never be re-triggered by a wrap.
          if (hcnt_q != HcntMax) begin
            hcnt_d = hcnt_q + HcntW'(1);
          end
          if (hcnt_q == HcntHold) begin
            hold_d = 1'b1;
          end
        end
      end
      StRWait: begin
        if (sync2_q) begin
          state_d = StPressed;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          btn_d   = 1'b0;
          hold_d  = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      btn_q   <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      btn_q   <= btn_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
    end
  end

  assign btn_o     = btn_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign hold_o    = hold_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: N_BTN independent debounced channels with press/release/hold.
module button_conditioner #(
  parameter int unsigned N_BTN           = 2,
  parameter bit          INV_BTN         = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned HOLD_CYCLES     = 27000000
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] hold_o
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_conditioner_ch #(
      .INV_BTN        (INV_BTN),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_i    (rst_i),
      .btn_raw_i(btn_raw_i[g]),
      .btn_o    (btn_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .hold_o   (hold_o[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: vector table plus reset and polarity sequences.
module tb_button_conditioner;

  logic       clk;
  logic       rst_i;
  logic [1:0] raw_a, raw_b;
  logic [1:0] btn_a, press_a, rel_a, hold_a;
  logic [1:0] btn_b, press_b, rel_b, hold_b;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] raw;
    logic [1:0] btn;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] hold;
  } vec_t;

  vec_t vecs[$];

  button_conditioner #(
    .N_BTN(2), .INV_BTN(1'b0), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10)
  ) dut (
    .clk(clk), .rst_i(rst_i), .btn_raw_i(raw_a),
    .btn_o(btn_a), .press_o(press_a), .release_o(rel_a), .hold_o(hold_a)
  );

  button_conditioner #(
    .N_BTN(2), .INV_BTN(1'b1), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10)
  ) dut_inv (
    .clk(clk), .rst_i(rst_i), .btn_raw_i(raw_b),
    .btn_o(btn_b), .press_o(press_b), .release_o(rel_b), .hold_o(hold_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string tag, input logic [1:0] b, input logic [1:0] p,
                       input logic [1:0] r, input logic [1:0] h);
    chk({tag, " btn"}, btn_a, b);
    chk({tag, " press"}, press_a, p);
    chk({tag, " release"}, rel_a, r);
    chk({tag, " hold"}, hold_a, h);
  endtask

  task automatic chk_b(input string tag, input logic [1:0] b, input logic [1:0] p,
                       input logic [1:0] r, input logic [1:0] h);
    chk({tag, " inv btn"}, btn_b, b);
    chk({tag, " inv press"}, press_b, p);
    chk({tag, " inv release"}, rel_b, r);
    chk({tag, " inv hold"}, hold_b, h);
  endtask

  function automatic void add(input logic [1:0] r, input logic [1:0] b, input logic [1:0] p,
                              input logic [1:0] rl, input logic [1:0] h);
    vecs.push_back('{raw: r, btn: b, press: p, rel: rl, hold: h});
  endfunction

  initial begin
    logic [11:0] pat;
    raw_a = 2'b00;
    raw_b = 2'b11;
    rst_i = 1'b1;

    // Clean press held 30 samples, then release: press at +5, hold at +15, release at +35.
    for (int i = 0; i < 39; i++)
      add({1'b0, i < 30}, {1'b0, i >= 5 && i < 35}, {1'b0, i == 5},
          {1'b0, i == 35}, {1'b0, i >= 15 && i < 35});
    // Press bounce 1,1,0,1,... : only the run starting at sample 3 is accepted.
    pat = 12'b1111_1111_1011;
    for (int i = 0; i < 20; i++)
      add({1'b0, (i < 12) ? pat[i] : 1'b0}, {1'b0, i >= 8 && i < 17}, {1'b0, i == 8},
          {1'b0, i == 17}, 2'b00);
    // Two-sample release bounce after hold has set; then a genuine release.
    for (int i = 0; i < 34; i++)
      add({1'b0, i < 20 || (i >= 22 && i < 26)}, {1'b0, i >= 5 && i < 31}, {1'b0, i == 5},
          {1'b0, i == 31}, {1'b0, i >= 15 && i < 31});
    // Channel 1 alone; channel 0 must stay quiet.
    for (int i = 0; i < 18; i++)
      add({i < 10, 1'b0}, {i >= 5 && i < 15, 1'b0}, {i == 5, 1'b0},
          {i == 15, 1'b0}, 2'b00);

    // Reset state
    #2 rst_i = 1'b0;
    #1;
    chk_a("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    chk_b("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    step();
    step();
    @(negedge clk);
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_a("idle", 2'b00, 2'b00, 2'b00, 2'b00);
      chk_b("idle", 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      raw_a = vecs[i].raw;
      step();
      chk_a($sformatf("vec%0d", i), vecs[i].btn, vecs[i].press, vecs[i].rel, vecs[i].hold);
    end

    // Reset during P_WAIT, raw held high throughout
    raw_a = 2'b01;
    for (int i = 0; i < 3; i++) step();
    #2 rst_i = 1'b0;
    #1;
    chk_a("rst pwait", 2'b00, 2'b00, 2'b00, 2'b00);
    step();
    chk_a("rst pwait held", 2'b00, 2'b00, 2'b00, 2'b00);
    #4 rst_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk_a($sformatf("post rst1 s%0d", i), {1'b0, i >= 6}, {1'b0, i == 6}, 2'b00,
            {1'b0, i >= 16});
    end

    // Reset during PRESSED with hold set
    #2 rst_i = 1'b0;
    #1;
    chk_a("rst pressed", 2'b00, 2'b00, 2'b00, 2'b00);
    step();
    chk_a("rst pressed held", 2'b00, 2'b00, 2'b00, 2'b00);
    #4 rst_i = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk_a($sformatf("post rst2 s%0d", i), {1'b0, i >= 6}, {1'b0, i == 6}, 2'b00, 2'b00);
    end
    raw_a = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk_a($sformatf("rel after rst s%0d", i), {1'b0, i < 6}, 2'b00, {1'b0, i == 6}, 2'b00);
    end

    // Active-low pads, both channels pressed and released on the same edge
    raw_b = 2'b00;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk_b($sformatf("inv press s%0d", i), {2{i >= 6}}, {2{i == 6}}, 2'b00, {2{i >= 16}});
    end
    raw_b = 2'b11;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk_b($sformatf("inv rel s%0d", i), {2{i < 6}}, 2'b00, {2{i == 6}}, {2{i < 6}});
    end
    chk_a("inv quiet other", 2'b00, 2'b00, 2'b00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
